// File: rtl/mod_add_serial.sv
// Limb-serial modular adder over Fp, p = 2^448 - 2^224 - 1.
// Sum and sum-minus-p are built per limb and the reduced one is selected at the end.

package parameters_pkg;
  localparam int DATA_WIDTH = 448;
  localparam logic [DATA_WIDTH-1:0] MODULUS =
    {{223{1'b1}}, 1'b0, {224{1'b1}}};
endpackage

module mod_add_serial #(
  parameter int DATA_WIDTH = parameters_pkg::DATA_WIDTH,
  parameter int LIMB_WIDTH = 64,
  parameter int NUM_LIMBS  = DATA_WIDTH / LIMB_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  done,
  output logic                  busy
);
  import parameters_pkg::*;

  localparam int CW = (NUM_LIMBS > 1) ? $clog2(NUM_LIMBS) : 1;
  localparam logic [CW-1:0] LAST = CW'(NUM_LIMBS - 1);
  localparam logic [DATA_WIDTH-1:0] P = DATA_WIDTH'(MODULUS);
  localparam int LW = LIMB_WIDTH;
  localparam int DW = DATA_WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    ADD,
    SELECT
  } state_t;

  state_t state;
  state_t state_nx;

  logic [DW-1:0] a_sh;
  logic [DW-1:0] b_sh;
  logic [DW-1:0] s_sh;
  logic [DW-1:0] t_sh;
  logic [CW-1:0] cnt;
  logic          carry;
  logic          borrow;
  logic [LW-1:0] p_limb;
  logic [LW:0]   sum_w;
  logic [LW:0]   dif_w;

  // per-limb sum and trial subtraction of p
  always_comb begin
    p_limb = P[cnt*LW +: LW];
    sum_w  = {1'b0, a_sh[LW-1:0]}
           + {1'b0, b_sh[LW-1:0]}
           + {{LW{1'b0}}, carry};
    dif_w  = {1'b0, sum_w[LW-1:0]}
           - {1'b0, p_limb}
           - {{LW{1'b0}}, borrow};
  end

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = ADD;
      ADD:     if (cnt == LAST) state_nx = SELECT;
      SELECT:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // operand capture, limb datapath and final selection
  always_ff @(posedge clk) begin
    if (rst) begin
      result <= '0;
      done   <= 1'b0;
      cnt    <= '0;
      carry  <= 1'b0;
      borrow <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            a_sh   <= a;
            b_sh   <= b;
            cnt    <= '0;
            carry  <= 1'b0;
            borrow <= 1'b0;
          end
        end
        ADD: begin
          a_sh   <= a_sh >> LW;
          b_sh   <= b_sh >> LW;
          s_sh   <= {sum_w[LW-1:0], s_sh[DW-1:LW]};
          t_sh   <= {dif_w[LW-1:0], t_sh[DW-1:LW]};
          carry  <= sum_w[LW];
          borrow <= dif_w[LW];
          cnt    <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
        SELECT: begin
          result <= (carry | ~borrow) ? t_sh : s_sh;
          done   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_mod_add_serial.sv
// Self-checking bench for mod_add_serial.
// Directed table, random ops, held start, and mid-operation reset.

module tb_mod_add_serial;
  import parameters_pkg::*;

  localparam int DW = DATA_WIDTH;
  localparam int LAT = 8;
  localparam logic [DW-1:0] P = MODULUS;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [DW-1:0] a;
  logic [DW-1:0] b;
  logic [DW-1:0] result;
  logic          done;
  logic          busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mod_add_serial dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .a(a),
    .b(b),
    .result(result),
    .done(done),
    .busy(busy)
  );

  typedef struct {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] exp;
    string         nm;
  } vec_t;

  function automatic logic [DW-1:0] ref_add(
    input logic [DW-1:0] x,
    input logic [DW-1:0] y
  );
    logic [DW:0] s;
    s = {1'b0, x} + {1'b0, y};
    if (s >= {1'b0, P}) s = s - {1'b0, P};
    return s[DW-1:0];
  endfunction

  function automatic logic [DW-1:0] rand_fe();
    logic [DW-1:0] r;
    for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
    if (r >= P) r = r - P;
    return r;
  endfunction

  task automatic chk(
    input string         nm,
    input logic [DW-1:0] act,
    input logic [DW-1:0] exp
  );
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  task automatic run_op(
    input logic [DW-1:0] x,
    input logic [DW-1:0] y,
    input logic [DW-1:0] exp,
    input string         nm
  );
    logic [DW-1:0] prev;
    int n;
    bit seen;
    prev  = result;
    a     = x;
    b     = y;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = rand_fe();
    b = rand_fe();
    chk({nm, " busy"}, busy, 1);
    chk({nm, " done_clr"}, done, 0);
    n = 0;
    seen = 0;
    while (!seen && n < 20) begin
      @(posedge clk); #1;
      n++;
      if (done) seen = 1;
      else begin
        chk({nm, " busy_run"}, busy, 1);
        if (n == 4) chk({nm, " hold"}, result, prev);
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s timeout got no done want done", nm);
    end else begin
      chk({nm, " latency"}, n, LAT);
      chk({nm, " result"}, result, exp);
      chk({nm, " busy_end"}, busy, 0);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  initial begin
    vec_t tbl[6];
    logic [DW-1:0] h447;
    logic [DW-1:0] e447;
    logic [DW-1:0] x;
    logic [DW-1:0] y;
    logic [DW-1:0] q[$];
    int cnt_m;
    int dn;
    bit exp_done;

    h447 = '0;
    h447[447] = 1'b1;
    e447 = '0;
    e447[224] = 1'b1;
    e447[0] = 1'b1;
    tbl[0] = '{'0, '0, '0, "zero"};
    tbl[1] = '{P - 1, 1, 0, "pm1_1"};
    tbl[2] = '{P - 1, 2, 1, "pm1_2"};
    tbl[3] = '{P - 1, P - 1, P - 2, "pm1_pm1"};
    tbl[4] = '{h447, h447, e447, "h447"};
    tbl[5] = '{5, 7, 12, "b2b_5_7"};

    rst = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst result", result, 0);
    chk("rst done", done, 0);
    chk("rst busy", busy, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++)
      run_op(tbl[i].a, tbl[i].b, tbl[i].exp, tbl[i].nm);

    for (int i = 0; i < 8; i++) begin
      x = rand_fe();
      y = rand_fe();
      if (i[0]) x = P - 1 - DW'($urandom_range(0, 15));
      run_op(x, y, ref_add(x, y), "rand");
    end

    cnt_m = 0;
    for (int c = 0; c < 34; c++) begin
      if (c < 20) begin
        start = 1'b1;
        a = rand_fe();
        b = rand_fe();
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      exp_done = 0;
      if (cnt_m == 0) begin
        if (start) begin
          q.push_back(ref_add(a, b));
          cnt_m = LAT;
        end
      end else begin
        cnt_m--;
        if (cnt_m == 0) exp_done = 1;
      end
      #1;
      chk("held done", done, exp_done);
      if (done && q.size() > 0) chk("held result", result, q.pop_front());
    end
    chk("held drain", q.size(), 0);

    a = rand_fe();
    b = rand_fe();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort result", result, 0);
    chk("abort done", done, 0);
    chk("abort busy", busy, 0);
    dn = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done) dn++;
    end
    chk("abort no_done", dn, 0);

    x = rand_fe();
    y = rand_fe();
    run_op(x, y, ref_add(x, y), "post_rst");
    @(posedge clk); #1;
    chk("pulse done_clr", done, 0);
    chk("pulse result_hold", result, ref_add(x, y));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mod_add_serial.md
Name: mod_add_serial

Overview:
- Multi-cycle modular adder in Fp, p = MODULUS = 2^448 - 2^224 - 1, taken from parameters_pkg.
- Inverse counterpart of the field subtractor. It is used by the point-arithmetic sequencers wherever a+b mod p is needed.
- Adds limb-serially, LIMB_WIDTH bits per cycle, so the carry chain stays short for timing.
- Computes s = a+b and t = s-p in parallel per limb, then selects the reduced result.

Parameters:
- DATA_WIDTH, 448, operand/result width (from parameters_pkg; must equal NUM_LIMBS*LIMB_WIDTH).
- LIMB_WIDTH, 64, bits processed per cycle.
- NUM_LIMBS, DATA_WIDTH/LIMB_WIDTH (=7), number of limb cycles.

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst  input  1  synchronous active-high reset.
- start  input  1  request; sampled only in IDLE.
- a  input  DATA_WIDTH  operand, must be < p; sampled on the accepting edge.
- b  input  DATA_WIDTH  operand, must be < p; sampled on the accepting edge.
- result  output  DATA_WIDTH  (a+b) mod p; held until the next completion.
- done  output  1  single-cycle completion pulse.
- busy  output  1  high from acceptance until done is asserted.

Behaviour:
- Reset (rst high at an edge): state=IDLE, result=0, done=0, busy=0, limb counter=0, carry=0, borrow=0. Reset overrides everything, including a mid-operation cycle; the aborted operation produces no done.
- States and transitions:
  - IDLE: start=1 at an edge latches a and b into internal shift registers, clears carry/borrow/counter, sets busy=1, and moves to ADD.
  - ADD, one limb per edge, LSB limb first, for limb i = counter:
    - {c', s_i} = a_i + b_i + carry (LIMB_WIDTH+1 bits).
    - {bw', t_i} = s_i - p_i - borrow.
    - s_i and t_i are stored in s/t shift registers; carry and borrow are updated.
    - counter increments; after limb NUM_LIMBS-1 the state moves to SELECT.
  - SELECT:
    - Final carry C and borrow B.
    - result <= (C | ~B) ? t : s. When C=1, t read modulo 2^448 is the correct value.
    - done <= 1, busy <= 0, then IDLE.
- done is high for exactly one cycle: the cycle after the SELECT edge. It is cleared on the following edge.
- Latency: if start is sampled at edge E0, result is valid and done=1 after edge E0+NUM_LIMBS+1 (8 for the defaults). Throughput is one operation per NUM_LIMBS+2 cycles.
- start while busy (ADD/SELECT) is ignored; operands are not re-sampled.
- start in the done cycle (state IDLE) is accepted: back-to-back operation.
- a and b may change after the accepting edge without effect.
- Operands >= p are outside the contract; the result is then unspecified but must not hang the FSM.
- result does not change except at a SELECT edge or reset.

Test Plan:
- Reset, then a=0, b=0, start pulse -> done exactly 8 cycles after the start edge, result=0, busy high for those 8 cycles.
- a=p-1, b=1 -> result=0 (s==p path, borrow clear, no carry).
- a=p-1, b=2 -> result=1; a=p-1, b=p-1 -> result=p-2 (sum carry path).
- a=2^447, b=2^447 -> result=2^224+1 (carry out of bit 447). Then a=5, b=7 back-to-back with start in the done cycle -> result=12, done 8 cycles later.
- start held high for 20 cycles with operands changing each cycle -> only operands from the first accepting edge and from each IDLE edge are used. Exactly one done per accepted operation, and the results match those operands.
- rst asserted at the 4th ADD cycle -> next cycle result=0, done=0, busy=0, state IDLE. No done follows. A new start then completes normally.
